mem_line_responder: RTL and testbench
=====================================

# mem_line_responder

Line-granular memory responder on the far side of the L1-to-L2 cache bus. It accepts one `mem_bus_req_t` load or store at a time from the cache arbiter and services it from an internal line array after a fixed latency. It answers with a one-cycle `mem_bus_resp_t.mem_ready` pulse, plus the line data on loads. It is the responder end of the same request/ready handshake the arbiter initiates.

## Interface
- `CACHE_LINE_SIZE`, 512: line width in bits (64 B); must match the bus struct.
- `DEPTH`, 256: number of lines stored; power of two, ≥2.
- `LATENCY`, 4: cycles from request sample to `mem_ready`; ≥1.

Ports:
- `clock`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low (`reset`=0 resets).
- `req`  in  `mem_bus_req_t`  `mem_addr` (58-bit line address), `mem_data_out` (line), `mem_req_load`, `mem_req_store`.
- `resp`  out  `mem_bus_resp_t`  `mem_ready` (1-cycle completion pulse), `mem_data` (line).

## Operation
- One transaction in flight; no queueing.
- FSM states: IDLE, BUSY, DONE, TURN.
  - IDLE: samples `req` each edge. If `mem_req_load|mem_req_store`: latch the request and go to BUSY with count=LATENCY-1, or go straight to DONE if LATENCY=1.
  - BUSY: decrement count; go to DONE on the edge where count==1.
  - DONE: `mem_ready`=1 for exactly this cycle, then go to TURN.
  - TURN: one mandatory turnaround cycle. `req` is ignored, because the arbiter may still present the finished request. Then go to IDLE.
- Line index is `mem_addr[$clog2(DEPTH)-1:0]`. Upper address bits are ignored, so addresses alias modulo DEPTH.
- Store: `mem_data_out` is written into the array on the accept edge. `mem_data` returns the stored line at DONE.
- Load: the array line is read on the accept edge into the response register. `mem_data` returns that line at DONE.
- Load and store both asserted: treated as a store; the load is ignored.
- Address, data or opcode changes after acceptance are ignored, because the request is latched.
- If the request drops mid-transaction (e.g. arbiter reset), the transaction still completes and `mem_ready` still pulses. An accepted store stays committed.
- `mem_data` holds the last returned line between transactions. It is meaningful only while `mem_ready`=1.
- The line array is not reset.

## Timing
- Reset values, applied immediately on `reset`=0:
  - FSM = IDLE, count = 0.
  - `mem_ready` = 0.
  - `mem_data` = 0.
- Reset mid-transaction aborts it: no `mem_ready` pulse. A store accepted before reset remains written.
- Request visible in cycle 0 → `mem_ready` high in cycle LATENCY only.
- Earliest next sample is the edge ending cycle LATENCY+2. Peak throughput is one line per LATENCY+2 cycles.
- `mem_ready` and `mem_data` are registered, with no combinational path from `req`.

## Configuration
- `MEM_RESPONDER_CHECK_EN` defined: protocol assertions are compiled in. `$fatal` on any of:
  - load and store asserted together when sampled;
  - a change of `mem_addr`, `mem_req_load` or `mem_req_store` during BUSY while a request is still asserted;
  - `mem_ready` asserted in any state other than DONE.
- Undefined: no checks. Functional behaviour is exactly as above, with store priority and changes ignored.

## Test plan
- Reset, then store line 0xA5-repeated at addr 0x10 with LATENCY=4, request held. Require `mem_ready`=1 only in cycle 4. Then load addr 0x10 accepted at cycle 6 → `mem_ready` in cycle 10 with `mem_data`=0xA5-repeated.
- DEPTH=256: store line X at addr 0x105, load addr 0x005 → returns X (aliasing).
- Request held through DONE and TURN, then kept asserted. Require exactly one pulse per LATENCY+2 cycles, with no extra pulse in the TURN cycle.
- Load and store both set, addr 0x20, data Y, macro undefined → line 0x20 = Y and `mem_data`=Y at ready. With the macro defined → `$fatal`.
- Drive `reset`=0 in cycle 2 of a store to addr 0x30 (data Z). Require `mem_ready`/`mem_data` = 0 immediately and no pulse afterwards. A later load of 0x30 returns Z.
- LATENCY=1: request in cycle 0 → `mem_ready` in cycle 1. Change the address in cycle 1 → the returned data reflects the original address.

Source files
------------

// File: rtl/mem_line_responder.sv
// mem_line_responder: fixed-latency line memory answering single L1-to-L2 bus requests.
// Define MEM_RESPONDER_CHECK_EN to compile in the protocol checker.

package mem_bus_pkg;
  localparam int CACHE_LINE_SIZE = 512;
  localparam int MEM_ADDR_W      = 58;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0]      mem_addr;
    logic [CACHE_LINE_SIZE-1:0] mem_data_out;
    logic                       mem_req_load;
    logic                       mem_req_store;
  } mem_bus_req_t;

  typedef struct packed {
    logic                       mem_ready;
    logic [CACHE_LINE_SIZE-1:0] mem_data;
  } mem_bus_resp_t;
endpackage

`ifdef MEM_RESPONDER_CHECK_EN
module mem_line_responder_checker #(
  parameter int ADDR_W = 58
) (
  input logic              clock,
  input logic              reset,
  input logic              idle_s,
  input logic              busy_s,
  input logic              done_s,
  input logic              accept_s,
  input logic [ADDR_W-1:0] mem_addr,
  input logic              mem_req_load,
  input logic              mem_req_store,
  input logic              mem_ready
);
  logic [ADDR_W-1:0] addr_r;
  logic              load_r;
  logic              store_r;

  // Snapshot of the raw request fields taken on the accept edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_r  <= '0;
      load_r  <= 1'b0;
      store_r <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= mem_addr;
      load_r  <= mem_req_load;
      store_r <= mem_req_store;
    end else begin
      addr_r  <= addr_r;
      load_r  <= load_r;
      store_r <= store_r;
    end
  end

  // Protocol rules checked on every rising edge outside reset
  always @(posedge clock) begin
    if (reset) begin
      if (idle_s) begin
        assert (!(mem_req_load && mem_req_store))
          else $fatal(1, "mem_line_responder: load and store asserted together");
      end
      if (busy_s && (mem_req_load || mem_req_store)) begin
        assert ((mem_addr == addr_r) && (mem_req_load == load_r) && (mem_req_store == store_r))
          else $fatal(1, "mem_line_responder: request changed while busy");
      end
      assert (!mem_ready || done_s)
        else $fatal(1, "mem_line_responder: mem_ready outside DONE");
    end
  end
endmodule
`endif

module mem_line_responder #(
  parameter int CACHE_LINE_SIZE = mem_bus_pkg::CACHE_LINE_SIZE,
  parameter int DEPTH           = 256,
  parameter int LATENCY         = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  mem_bus_pkg::mem_bus_req_t  req,
  output mem_bus_pkg::mem_bus_resp_t resp
);
  localparam int ADDR_W      = mem_bus_pkg::MEM_ADDR_W;
  localparam int IDX_W       = $clog2(DEPTH);
  localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam bit DIRECT_DONE = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    TURN = 2'd3
  } state_t;

  state_t                     state_r;
  state_t                     state_s;
  logic [CNT_W-1:0]           count_r;
  logic [CNT_W-1:0]           count_s;
  logic                       accept_s;
  logic                       write_en_s;
  logic [IDX_W-1:0]           idx_s;
  logic [CACHE_LINE_SIZE-1:0] accept_line_s;
  logic [CACHE_LINE_SIZE-1:0] done_line_s;
  logic [CACHE_LINE_SIZE-1:0] line_r;
  logic                       mem_ready_r;
  logic [CACHE_LINE_SIZE-1:0] mem_data_r;
  logic [CACHE_LINE_SIZE-1:0] mem_r [DEPTH];
  logic                       unused_addr_s;

  // Upper address bits alias onto the same line
  assign idx_s         = req.mem_addr[IDX_W-1:0];
  assign unused_addr_s = ^req.mem_addr[ADDR_W-1:IDX_W];

  // A simultaneous load is dropped in favour of the store
  assign accept_line_s = req.mem_req_store ? req.mem_data_out : mem_r[idx_s];
  assign done_line_s   = accept_s ? accept_line_s : line_r;
  assign write_en_s    = accept_s && req.mem_req_store && reset;

  // Next-state and countdown logic
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req.mem_req_load || req.mem_req_store) begin
          accept_s = 1'b1;
          if (DIRECT_DONE) begin
            state_s = DONE;
            count_s = '0;
          end else begin
            state_s = BUSY;
            count_s = CNT_W'(LATENCY - 1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        count_s = count_r - CNT_W'(1);
        if (count_r == CNT_W'(1)) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        state_s = TURN;
      end
      TURN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        count_s = '0;
      end
    endcase
  end

  // FSM state, countdown and the line captured at acceptance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      count_r <= '0;
      line_r  <= '0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      if (accept_s) begin
        line_r <= accept_line_s;
      end else begin
        line_r <= line_r;
      end
    end
  end

  // Line array, deliberately left without reset
  always_ff @(posedge clock) begin
    if (write_en_s) begin
      mem_r[idx_s] <= req.mem_data_out;
    end
  end

  // Registered response: pulse and line loaded on the edge entering DONE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_ready_r <= 1'b0;
      mem_data_r  <= '0;
    end else begin
      mem_ready_r <= (state_s == DONE);
      if (state_s == DONE) begin
        mem_data_r <= done_line_s;
      end else begin
        mem_data_r <= mem_data_r;
      end
    end
  end

  assign resp.mem_ready = mem_ready_r;
  assign resp.mem_data  = mem_data_r;

`ifdef MEM_RESPONDER_CHECK_EN
  mem_line_responder_checker #(
    .ADDR_W(ADDR_W)
  ) u_checker (
    .clock        (clock),
    .reset        (reset),
    .idle_s       (state_r == IDLE),
    .busy_s       (state_r == BUSY),
    .done_s       (state_r == DONE),
    .accept_s     (accept_s),
    .mem_addr     (req.mem_addr),
    .mem_req_load (req.mem_req_load),
    .mem_req_store(req.mem_req_store),
    .mem_ready    (resp.mem_ready)
  );
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: a LATENCY=4 instance and a LATENCY=1 instance.
`timescale 1ns/1ps
module tb_mem_line_responder;
  import mem_bus_pkg::*;

  localparam int LW = 512;

  logic          clock = 1'b0;
  logic          reset_a_s;
  logic          reset_b_s;
  mem_bus_req_t  req_a_s;
  mem_bus_req_t  req_b_s;
  mem_bus_resp_t resp_a_s;
  mem_bus_resp_t resp_b_s;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clock = ~clock;

  mem_line_responder #(.CACHE_LINE_SIZE(LW), .DEPTH(256), .LATENCY(4)) dut_a (
    .clock(clock), .reset(reset_a_s), .req(req_a_s), .resp(resp_a_s)
  );

  mem_line_responder #(.CACHE_LINE_SIZE(LW), .DEPTH(256), .LATENCY(1)) dut_b (
    .clock(clock), .reset(reset_b_s), .req(req_b_s), .resp(resp_b_s)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel_b, input logic [57:0] addr, input logic [LW-1:0] data,
                       input logic ld, input logic st);
    mem_bus_req_t r;
    r.mem_addr      = addr;
    r.mem_data_out  = data;
    r.mem_req_load  = ld;
    r.mem_req_store = st;
    if (sel_b) req_b_s = r;
    else       req_a_s = r;
  endtask

  task automatic idle_req(input bit sel_b);
    drive(sel_b, 58'd0, {LW{1'b0}}, 1'b0, 1'b0);
  endtask

  // One transaction presented for a single cycle; leaves the DUT back in IDLE
  task automatic txn(input string tag, input bit sel_b, input logic [57:0] addr,
                     input logic [LW-1:0] data, input logic ld, input logic st,
                     input logic [LW-1:0] exp);
    int            lat;
    mem_bus_resp_t r;
    lat = sel_b ? 1 : 4;
    drive(sel_b, addr, data, ld, st);
    for (int k = 1; k <= lat + 1; k++) begin
      tick;
      if (k == 1) idle_req(sel_b);
      r = sel_b ? resp_b_s : resp_a_s;
      check_bit($sformatf("%s ready c%0d", tag, k), r.mem_ready, (k == lat));
      if (k == lat) check({tag, " data"}, r.mem_data, exp);
    end
    tick;
  endtask

  initial begin
    logic [LW-1:0] line_a5, line_x, line_y, line_z, line_p, line_q;
    line_a5 = {64{8'hA5}};
    line_x  = {16{32'hDEAD_BEEF}};
    line_y  = {8{64'h0123_4567_89AB_CDEF}};
    line_z  = {32{16'h5A3C}};
    line_p  = {4{128'h1111_2222_3333_4444_5555_6666_7777_8888}};
    line_q  = {64{8'h3C}};

    reset_a_s = 1'b0;
    reset_b_s = 1'b0;
    idle_req(1'b0);
    idle_req(1'b1);
    tick;
    tick;
    check_bit("reset ready a", resp_a_s.mem_ready, 1'b0);
    check("reset data a", resp_a_s.mem_data, {LW{1'b0}});
    check_bit("reset ready b", resp_b_s.mem_ready, 1'b0);
    check("reset data b", resp_b_s.mem_data, {LW{1'b0}});
    reset_a_s = 1'b1;
    reset_b_s = 1'b1;
    tick;

    // Held store at 0x10, then a load of 0x10 switched in during TURN
    drive(1'b0, 58'h10, line_a5, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      tick;
      check_bit($sformatf("st/ld ready c%0d", k), resp_a_s.mem_ready, (k == 4) || (k == 10));
      if (k == 4 || k == 10) check($sformatf("st/ld data c%0d", k), resp_a_s.mem_data, line_a5);
      if (k == 5) drive(1'b0, 58'h10, line_q, 1'b1, 1'b0);
      if (k == 10) idle_req(1'b0);
    end

    // Aliasing modulo DEPTH
    txn("alias st", 1'b0, 58'h105, line_x, 1'b0, 1'b1, line_x);
    txn("alias ld", 1'b0, 58'h005, line_q, 1'b1, 1'b0, line_x);

    // Continuously held load: one pulse every LATENCY+2 cycles
    drive(1'b0, 58'h105, line_q, 1'b1, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      tick;
      check_bit($sformatf("tput ready c%0d", k), resp_a_s.mem_ready, (k % 6) == 4);
      if ((k % 6) == 4) check($sformatf("tput data c%0d", k), resp_a_s.mem_data, line_x);
    end
    idle_req(1'b0);

    // Load and store together behave as a store
    txn("both", 1'b0, 58'h20, line_y, 1'b1, 1'b1, line_y);
    txn("both rd", 1'b0, 58'h20, line_q, 1'b1, 1'b0, line_y);

    // Reset in cycle 2 of a store aborts the response but keeps the write
    drive(1'b0, 58'h30, line_z, 1'b0, 1'b1);
    tick;
    tick;
    reset_a_s = 1'b0;
    idle_req(1'b0);
    #1;
    check_bit("midrst ready", resp_a_s.mem_ready, 1'b0);
    check("midrst data", resp_a_s.mem_data, {LW{1'b0}});
    tick;
    reset_a_s = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      check_bit($sformatf("postrst ready c%0d", k), resp_a_s.mem_ready, 1'b0);
    end
    txn("postrst ld", 1'b0, 58'h30, line_q, 1'b1, 1'b0, line_z);

    // LATENCY=1 instance
    txn("b st40", 1'b1, 58'h40, line_p, 1'b0, 1'b1, line_p);
    txn("b st41", 1'b1, 58'h41, line_q, 1'b0, 1'b1, line_q);
    drive(1'b1, 58'h40, line_z, 1'b1, 1'b0);
    tick;
    check_bit("b ld ready c1", resp_b_s.mem_ready, 1'b1);
    check("b ld data c1", resp_b_s.mem_data, line_p);
    drive(1'b1, 58'h41, line_z, 1'b1, 1'b0);
    tick;
    check_bit("b turn ready c2", resp_b_s.mem_ready, 1'b0);
    idle_req(1'b1);
    tick;
    check_bit("b idle ready c3", resp_b_s.mem_ready, 1'b0);
    check("b hold data c3", resp_b_s.mem_data, line_p);
    tick;
    check_bit("b idle ready c4", resp_b_s.mem_ready, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
